// File: rtl/lector_glifos_pkg.sv
// Shared definitions for the glyph reader: address/row widths, default glyph map, FSM encoding.
package lector_glifos_pkg;
  localparam int ADDR_W = 11;
  localparam int ROW_W  = 8;
  localparam int FILA_W = 6;
  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 11'h420;
  localparam logic [ADDR_W-1:0] STRIDE_DEF    = 11'h030;

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, PRESENT} estado_t;
endpackage

// File: rtl/lector_glifos_calc.sv
// Glyph row address: BASE_ADDR + STRIDE*nibble + row, wrapping at 11 bits; non-BCD nibbles map to base 0.
module calc_direccion_glifo
  import lector_glifos_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [ADDR_W-1:0] STRIDE    = STRIDE_DEF
) (
  input  logic [3:0]        nibble,
  input  logic [FILA_W-1:0] fila,
  output logic [ADDR_W-1:0] addr,
  output logic              invalido
);
  logic [ADDR_W-1:0] base;

  assign invalido = nibble > 4'd9;
  assign base     = invalido ? '0 : BASE_ADDR + STRIDE * ADDR_W'(nibble);
  assign addr     = base + ADDR_W'(fila);
endmodule

// File: rtl/lector_glifos.sv
// Reads two BCD glyphs (tens then units) row by row from ROM and presents them on a valid/ready port.
// Optional GLIFO_ERR_EN: non-BCD digits raise err and present blank rows without ROM reads.
module lector_glifos
  import lector_glifos_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [ADDR_W-1:0] STRIDE    = STRIDE_DEF,
  parameter int                ROWS      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        dato,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROW_W-1:0]  rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic              out_sel,
  output logic              out_last,
  output logic              busy,
  output logic              err
);
  localparam logic [FILA_W-1:0] LAST_ROW = FILA_W'(ROWS - 1);

  estado_t           estado;
  logic [7:0]        dato_q;
  logic [FILA_W-1:0] fila;
  logic              skip;
  logic [3:0]        c_nib;
  logic [FILA_W-1:0] c_row;
  logic              c_sel, c_inv, c_skip;
  logic [ADDR_W-1:0] c_addr;

  // Row that the next FETCH will target (only consumed on start or on acceptance).
  always_comb begin
    c_nib = out_sel ? dato_q[3:0] : dato_q[7:4];
    c_row = fila;
    c_sel = out_sel;
    if (estado == IDLE) begin
      c_nib = dato[7:4];
      c_row = '0;
      c_sel = 1'b0;
    end else if (fila != LAST_ROW) begin
      c_row = fila + 1'b1;
    end else begin
      c_nib = dato_q[3:0];
      c_row = '0;
      c_sel = 1'b1;
    end
  end

  calc_direccion_glifo #(.BASE_ADDR(BASE_ADDR), .STRIDE(STRIDE)) u_calc (
    .nibble  (c_nib),
    .fila    (c_row),
    .addr    (c_addr),
    .invalido(c_inv)
  );

`ifdef GLIFO_ERR_EN
  assign c_skip = c_inv;
`else
  assign c_skip = 1'b0;
`endif

  // A skipped row still spends its FETCH cycle (strobe held low) so row timing is unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado    <= IDLE;
      dato_q    <= '0;
      fila      <= '0;
      skip      <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (estado)
        IDLE: if (start) begin
          dato_q   <= dato;
          fila     <= '0;
          out_sel  <= 1'b0;
          err      <= c_skip;
          skip     <= c_skip;
          rom_en   <= ~c_skip;
          rom_addr <= c_addr;
          busy     <= 1'b1;
          estado   <= FETCH;
        end
        FETCH: begin
          rom_en <= 1'b0;
          estado <= LATCH;
        end
        LATCH: begin
          out_data  <= skip ? '0 : rom_data;
          out_valid <= 1'b1;
          out_last  <= out_sel && (fila == LAST_ROW);
          estado    <= PRESENT;
        end
        PRESENT: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (out_sel && fila == LAST_ROW) begin
            busy   <= 1'b0;
            estado <= IDLE;
          end else begin
            fila     <= c_row;
            out_sel  <= c_sel;
            err      <= err | c_skip;
            skip     <= c_skip;
            rom_en   <= ~c_skip;
            rom_addr <= c_addr;
            estado   <= FETCH;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lector_glifos.sv
// Directed bench for lector_glifos: full requests, backpressure, start-while-busy, non-BCD digits, mid-run reset.
module tb_lector_glifos;
  localparam int ROWS = 16;
`ifdef GLIFO_ERR_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [7:0]  dato;
  logic        rom_en, out_valid, out_sel, out_last, busy, err;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data, out_data;
  logic [10:0] first_addr [2];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lector_glifos #(.ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .start(start), .dato(dato),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_last(out_last), .busy(busy), .err(err)
  );

  // ROM with one-cycle read latency; garbage when not strobed exposes mistimed capture.
  always @(posedge clk) rom_data <= rom_en ? (rom_addr[7:0] ^ 8'h5A) : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] exp_addr(input logic [3:0] n, input int row);
    if (n > 4'd9) return 11'(row);
    return 11'(32'h420 + 32'h30 * n + row);
  endfunction

  task automatic run_req(input logic [7:0] d, input int stall_at, input int poke_at, input int abort_at);
    int waits, nf;
    logic [3:0]  nib;
    logic        sk;
    logic [10:0] a;
    logic [7:0]  ed, hold;
    first_addr[0] = 11'h7FF;
    first_addr[1] = 11'h7FF;
    @(negedge clk); start = 1'b1; dato = d;
    @(negedge clk); start = 1'b0; dato = 8'h77;
    for (int r = 0; r < 2*ROWS; r++) begin
      nib = (r < ROWS) ? d[7:4] : d[3:0];
      sk  = SKIP_EN && (nib > 4'd9);
      a   = exp_addr(nib, r % ROWS);
      ed  = sk ? 8'h00 : (a[7:0] ^ 8'h5A);
      waits = 0; nf = 0;
      while (!out_valid && waits < 20) begin
        if (rom_en) begin
          nf++;
          chk("addr", rom_addr, a);
          if (r % ROWS == 0) first_addr[r / ROWS] = rom_addr;
        end
        waits++;
        @(negedge clk);
      end
      chk("lat", waits, 2);
      chk("nfetch", nf, sk ? 0 : 1);
      chk("data", out_data, ed);
      chk("sel", out_sel, r >= ROWS);
      chk("last", out_last, r == 2*ROWS-1);
      if (r == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_outs", {rom_en, out_sel, out_last, err, rom_addr, out_data}, 0);
        @(negedge clk); reset = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("quiet", {out_valid, rom_en, busy}, 0);
        end
        return;
      end
      if (r == stall_at) begin
        out_ready = 1'b0;
        hold = out_data;
        repeat (5) begin
          @(negedge clk);
          chk("hold_data", out_data, hold);
          chk("hold_sel", out_sel, r >= ROWS);
          chk("hold_valid", out_valid, 1);
          chk("hold_noen", rom_en, 0);
        end
        out_ready = 1'b1;
      end
      if (r == poke_at) begin start = 1'b1; dato = 8'h99; end
      @(negedge clk);
      start = 1'b0;
    end
    chk("end_busy", busy, 0);
    chk("end_ov", out_valid, 0);
    chk("end_err", err, SKIP_EN && (d[7:4] > 4'd9 || d[3:0] > 4'd9));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dato = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_outs", {rom_en, out_valid, out_sel, out_last, err, rom_addr, out_data}, 0);
    reset = 1'b0;

    run_req(8'h00, -1, 3, -1);
    chk("t00", first_addr[0], 11'h420);
    chk("u00", first_addr[1], 11'h420);

    run_req(8'h93, 20, -1, -1);
    chk("t93", first_addr[0], 11'h5D0);
    chk("u93", first_addr[1], 11'h4B0);

    run_req(8'hA5, 5, -1, -1);
    chk("tA5", first_addr[0], SKIP_EN ? 11'h7FF : 11'h000);
    chk("uA5", first_addr[1], 11'h510);

    run_req(8'h00, -1, -1, 6);

    run_req(8'h93, -1, -1, -1);
    chk("t93b", first_addr[0], 11'h5D0);
    chk("u93b", first_addr[1], 11'h4B0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
